iic_dsmod_feed: RTL and testbench
=================================

# iic_dsmod_feed

Sample feeder stage that sits directly upstream of the delta-sigma modulator. It accepts 16-bit audio samples from the system side over a valid/ready handshake and buffers them in a small FIFO. It presents the current sample to the modulator as unsigned offset-binary and advances one word each time the modulator requests the next sample. Underruns produce mid-scale (silence) and raise a sticky flag, so the bitstream never carries garbage.

## Interface
- DW, 16, sample width in bits (≥ 2)
- DEPTH, 8, FIFO depth in words; power of two, ≥ 2
- clk_i  in  1  modulator clock; single clock domain
- rst_i  in  1  reset, synchronous, active-high
- in_data_i  in  DW  sample from system side; two's complement or unsigned, per fmt_i
- in_valid_i  in  1  in_data_i valid
- in_ready_o  out  1  FIFO can accept a word
- fmt_i  in  1  input format: 0 = two's complement, 1 = already unsigned offset-binary
- data_o  out  DW  current sample to modulator, unsigned offset-binary
- data_rd_i  in  1  one-cycle strobe from modulator: advance to next sample
- level_o  out  $clog2(DEPTH)+1  words currently stored, 0..DEPTH
- empty_o  out  1  level_o == 0
- full_o  out  1  level_o == DEPTH
- underrun_o  out  1  sticky: a data_rd_i arrived while the FIFO was empty
- underrun_clr_i  in  1  clears underrun_o

## Operation
- Push: in_valid_i & in_ready_o at a rising edge writes in_data_i at the write pointer, which then increments mod DEPTH.
- in_ready_o = !full_o & !rst_i.
- Pop: data_rd_i high at a rising edge.
  - FIFO non-empty: data_o ← conv(head), read pointer increments mod DEPTH.
  - FIFO empty: data_o ← MIDSCALE (1 << (DW-1)), underrun_o ← 1, pointers unchanged.
- conv(x) = x with MSB inverted when fmt_i = 0, x unchanged when fmt_i = 1. fmt_i is sampled at pop time and is expected to be static during streaming.
- Without data_rd_i, data_o holds its value indefinitely. The modulator consumes a held value.
- Simultaneous push and pop, FIFO neither empty nor full: both occur, level_o unchanged.
- Simultaneous push and pop, FIFO empty: the word is stored, the pop is an underrun (no bypass), and level_o becomes 1.
- FIFO full and pop in the same cycle: no push, because in_ready_o was low. level_o decrements.
- underrun_clr_i and a new underrun in the same cycle: set wins, and underrun_o stays 1.
- Pointers are $clog2(DEPTH) bits wide. The level counter is one bit wider and saturates by construction: no push when full, no decrement when empty.
- Reset (rst_i high at an edge) applies regardless of in-flight handshakes.
  - data_o = MIDSCALE, level_o = 0, empty_o = 1, full_o = 0, underrun_o = 0, pointers = 0.
  - Stored contents are discarded.

## Timing
- All outputs are registered or decoded from registers only. No combinational path from any input to any output except in_ready_o from rst_i.
- A word pushed at edge N is counted in level_o after edge N and can be popped at edge N+1 or later.
- A pop at edge N updates data_o after edge N. The modulator samples the new value from cycle N+1.
- Sustained throughput is one push and one pop per cycle. The modulator actually pops once per OSR cycles (32..256).
- The first in_ready_o = 1 is in the cycle after rst_i deasserts.

## Structure
- Package iic_dsmod_pkg holds:
  - the MIDSCALE function/constant of DW;
  - the fmt encoding constants FMT_TWOS = 0 and FMT_UNSIGNED = 1;
  - the shared DW default.
- Sub-module iic_sync_fifo (parameters DW, DEPTH) contains storage, pointers, level, and the empty/full flags.
- The top level adds format conversion, the data_o register, and the underrun logic.

## Test plan
- Reset: hold rst_i for 3 cycles with in_valid_i = 1 → data_o = 0x8000, level_o = 0, in_ready_o = 0 during reset and 1 on the next cycle.
- Push 0x0000, 0x7FFF, 0x8000, 0xFFFF with fmt_i = 0, then pulse data_rd_i 4 times → data_o = 0x8000, 0xFFFF, 0x0000, 0x7FFF. Repeat with fmt_i = 1 → values unchanged.
- Fill to DEPTH = 8 → full_o = 1, in_ready_o = 0, and a 9th offered word is not taken. Then do one pop with in_valid_i held → level_o goes 8→7→8, and FIFO order is preserved across pointer wrap.
- data_rd_i while empty → data_o = 0x8000, underrun_o = 1, level_o stays 0. Assert underrun_clr_i together with another empty pop → underrun_o stays 1. Clear alone → 0.
- Push and pop in the same cycle at level 3 → level_o stays 3 and data_o equals the oldest word. At level 0 → underrun, and level_o = 1.
- Assert rst_i mid-stream at level 5 → all outputs return to their reset values the next cycle, and a following pop underruns.

Source files
------------

// File: rtl/iic_dsmod_pkg.sv
// iic_dsmod_pkg: shared constants for the delta-sigma modulator feeder.
//   DW_DEFAULT   - default sample width
//   FMT_TWOS     - fmt_i code for two's complement input
//   FMT_UNSIGNED - fmt_i code for offset-binary input
//   midscale()   - silence code (1 << (dw-1)) for a given width
package iic_dsmod_pkg;

  localparam int unsigned DW_DEFAULT = 16;

  localparam logic FMT_TWOS     = 1'b0;
  localparam logic FMT_UNSIGNED = 1'b1;

  // Returned 32 bits wide; callers cast down to their own DW.
  function automatic logic [31:0] midscale(input int unsigned dw);
    return 32'(1) << (dw - 1);
  endfunction

endpackage

// File: rtl/iic_sync_fifo.sv
// iic_sync_fifo: single-clock FIFO with occupancy counter.
//   clk_i, rst_i  - clock, synchronous active-high reset
//   wr_data_i     - word to store
//   push_i        - store wr_data_i (caller guarantees !full_o)
//   pop_i         - drop head word (caller guarantees !empty_o)
//   rd_data_o     - head word (decoded from storage and read pointer)
//   level_o       - words stored, 0..DEPTH
//   empty_o       - level_o == 0
//   full_o        - level_o == DEPTH
module iic_sync_fifo
  import iic_dsmod_pkg::*;
#(
  parameter int unsigned DW    = DW_DEFAULT,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [DW-1:0]              wr_data_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  output logic [DW-1:0]              rd_data_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q,  level_d;

  // Pointer and level next-state; power-of-two depth wraps naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_i, pop_i})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; the level counter alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i && !rst_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;
  assign empty_o   = (level_q == '0);
  assign full_o    = (level_q == LW'(DEPTH));

endmodule

// File: rtl/iic_dsmod_feed.sv
// iic_dsmod_feed: buffers system-side samples and hands them to the
// delta-sigma modulator as offset-binary, one word per data_rd_i strobe.
//   clk_i, rst_i    - clock, synchronous active-high reset
//   in_data_i/in_valid_i/in_ready_o - system-side push handshake
//   fmt_i           - 0: two's complement input, 1: offset-binary input
//   data_o          - registered sample to modulator
//   data_rd_i       - modulator advance strobe
//   level_o/empty_o/full_o - FIFO occupancy
//   underrun_o      - sticky, set by a strobe while empty
//   underrun_clr_i  - clears underrun_o (a simultaneous underrun wins)
module iic_dsmod_feed
  import iic_dsmod_pkg::*;
#(
  parameter int unsigned DW    = DW_DEFAULT,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DW-1:0]          in_data_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic                   fmt_i,
  output logic [DW-1:0]          data_o,
  input  logic                   data_rd_i,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic                   underrun_o,
  input  logic                   underrun_clr_i
);

  localparam logic [DW-1:0] MIDSCALE = DW'(midscale(DW));

  logic          ready;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic [DW-1:0] head;
  logic [DW-1:0] data_q,     data_d;
  logic          underrun_q, underrun_d;

  // Ready drops combinationally with reset so nothing is offered into a clearing FIFO.
  assign ready = !fifo_full && !rst_i;
  assign push  = in_valid_i && ready;
  assign pop   = data_rd_i && !fifo_empty;

  iic_sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_data_i (in_data_i),
    .push_i    (push),
    .pop_i     (pop),
    .rd_data_o (head),
    .level_o   (level_o),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  // Output sample and sticky underrun next-state; an empty strobe yields silence.
  always_comb begin
    data_d     = data_q;
    underrun_d = underrun_q;
    if (underrun_clr_i) underrun_d = 1'b0;
    if (data_rd_i) begin
      if (fifo_empty) begin
        data_d     = MIDSCALE;
        underrun_d = 1'b1;
      end else if (fmt_i == FMT_TWOS) begin
        data_d = head ^ MIDSCALE;
      end else begin
        data_d = head;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q     <= MIDSCALE;
      underrun_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      underrun_q <= underrun_d;
    end
  end

  assign in_ready_o = ready;
  assign data_o     = data_q;
  assign empty_o    = fifo_empty;
  assign full_o     = fifo_full;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_iic_dsmod_feed.sv
module tb_iic_dsmod_feed;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [DW-1:0] in_data_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic          fmt_i;
  logic [DW-1:0] data_o;
  logic          data_rd_i;
  logic [3:0]    level_o;
  logic          empty_o;
  logic          full_o;
  logic          underrun_o;
  logic          underrun_clr_i;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  iic_dsmod_feed #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .in_data_i      (in_data_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .fmt_i          (fmt_i),
    .data_o         (data_o),
    .data_rd_i      (data_rd_i),
    .level_o        (level_o),
    .empty_o        (empty_o),
    .full_o         (full_o),
    .underrun_o     (underrun_o),
    .underrun_clr_i (underrun_clr_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] v);
    in_data_i  = v;
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic pop();
    data_rd_i = 1'b1;
    tick();
    data_rd_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; in_data_i = 16'h1234; in_valid_i = 1'b1; fmt_i = 1'b0;
    data_rd_i = 1'b0; underrun_clr_i = 1'b0;

    // Reset held 3 cycles with valid asserted.
    repeat (3) tick();
    chk("rst_ready", in_ready_o, 0);
    chk("rst_data", data_o, 16'h8000);
    chk("rst_level", level_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_underrun", underrun_o, 0);
    rst_i = 1'b0; in_valid_i = 1'b0;
    #1;
    chk("post_rst_ready", in_ready_o, 1);

    // Two's complement conversion.
    fmt_i = 1'b0;
    push(16'h0000); push(16'h7FFF); push(16'h8000); push(16'hFFFF);
    chk("tc_level4", level_o, 4);
    pop(); chk("tc_pop0", data_o, 16'h8000);
    pop(); chk("tc_pop1", data_o, 16'hFFFF);
    pop(); chk("tc_pop2", data_o, 16'h0000);
    pop(); chk("tc_pop3", data_o, 16'h7FFF);
    chk("tc_level0", level_o, 0);
    tick(); chk("hold_data", data_o, 16'h7FFF);

    // Offset-binary pass-through.
    fmt_i = 1'b1;
    push(16'h0000); push(16'h7FFF); push(16'h8000); push(16'hFFFF);
    pop(); chk("ub_pop0", data_o, 16'h0000);
    pop(); chk("ub_pop1", data_o, 16'h7FFF);
    pop(); chk("ub_pop2", data_o, 16'h8000);
    pop(); chk("ub_pop3", data_o, 16'hFFFF);
    chk("ub_underrun", underrun_o, 0);

    // Fill to full, 9th word refused.
    for (int i = 0; i < 8; i++) push(16'h1000 + 16'(i));
    chk("fill_level", level_o, 8);
    chk("fill_full", full_o, 1);
    chk("fill_ready", in_ready_o, 0);
    push(16'hDEAD);
    chk("ninth_level", level_o, 8);

    // Pop from full with valid held: 8 -> 7 -> 8.
    in_data_i = 16'hBEEF; in_valid_i = 1'b1; data_rd_i = 1'b1;
    tick();
    data_rd_i = 1'b0;
    chk("fullpop_level7", level_o, 7);
    chk("fullpop_data", data_o, 16'h1000);
    tick();
    in_valid_i = 1'b0;
    chk("refill_level8", level_o, 8);
    for (int i = 1; i < 8; i++) begin
      pop(); chk("wrap_order", data_o, 16'h1000 + 32'(i));
    end
    pop(); chk("wrap_last", data_o, 16'hBEEF);
    chk("wrap_empty", empty_o, 1);

    // Underrun and clear priority.
    pop();
    chk("ur_data", data_o, 16'h8000);
    chk("ur_flag", underrun_o, 1);
    chk("ur_level", level_o, 0);
    underrun_clr_i = 1'b1; data_rd_i = 1'b1;
    tick();
    underrun_clr_i = 1'b0; data_rd_i = 1'b0;
    chk("ur_set_wins", underrun_o, 1);
    underrun_clr_i = 1'b1;
    tick();
    underrun_clr_i = 1'b0;
    chk("ur_cleared", underrun_o, 0);

    // Simultaneous push/pop at level 3.
    push(16'h0A0A); push(16'h0B0B); push(16'h0C0C);
    in_data_i = 16'h0D0D; in_valid_i = 1'b1; data_rd_i = 1'b1;
    tick();
    in_valid_i = 1'b0; data_rd_i = 1'b0;
    chk("pp3_level", level_o, 3);
    chk("pp3_data", data_o, 16'h0A0A);
    pop(); chk("pp3_d1", data_o, 16'h0B0B);
    pop(); chk("pp3_d2", data_o, 16'h0C0C);
    pop(); chk("pp3_d3", data_o, 16'h0D0D);
    chk("pp3_no_ur", underrun_o, 0);

    // Simultaneous push/pop at level 0: no bypass.
    in_data_i = 16'h0E0E; in_valid_i = 1'b1; data_rd_i = 1'b1;
    tick();
    in_valid_i = 1'b0; data_rd_i = 1'b0;
    chk("pp0_underrun", underrun_o, 1);
    chk("pp0_data", data_o, 16'h8000);
    chk("pp0_level", level_o, 1);
    pop(); chk("pp0_later", data_o, 16'h0E0E);

    // Mid-stream reset at level 5.
    for (int i = 0; i < 5; i++) push(16'h2000 + 16'(i));
    pop();
    push(16'h2005);
    chk("mid_level5", level_o, 5);
    rst_i = 1'b1; in_valid_i = 1'b1; in_data_i = 16'h3333;
    #1;
    chk("mid_rst_ready", in_ready_o, 0);
    tick();
    chk("mid_rst_data", data_o, 16'h8000);
    chk("mid_rst_level", level_o, 0);
    chk("mid_rst_empty", empty_o, 1);
    chk("mid_rst_full", full_o, 0);
    chk("mid_rst_underrun", underrun_o, 0);
    rst_i = 1'b0; in_valid_i = 1'b0;
    pop();
    chk("post_rst_ur", underrun_o, 1);
    chk("post_rst_data", data_o, 16'h8000);
    chk("post_rst_level", level_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
